fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one byte-wide FIFO write port among NREQ producers. It keeps a local credit counter that mirrors free FIFO slots, so it never issues a write the FIFO would drop. It sits between the producer blocks and the FIFO: it drives the FIFO's wr_en/din and observes the FIFO's successful reads.

---
 rtl/fifo_arb_pkg.sv | 34 +++
 rtl/fifo_credit_ctr.sv | 40 ++++
 rtl/fifo_wr_arbiter.sv | 111 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and round-robin pick helper for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  localparam int MAX_NREQ      = 8;
  localparam int DEPTH_DEFAULT = 8;
  localparam int CW            = $clog2(DEPTH_DEFAULT + 1);

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_pick_t;

  // Scans ptr, ptr+1, ... mod nreq; walking downwards lets the nearest hit win.
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                       input logic [2:0]          ptr,
                                       input int                  nreq);
    rr_pick_t p;
    int       j;
    p = '0;
    for (int k = MAX_NREQ - 1; k >= 0; k--) begin
      if (k < nreq) begin
        j = (int'(ptr) + k) % nreq;
        if (req[j[2:0]]) begin
          p.valid = 1'b1;
          p.idx   = j[2:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/fifo_credit_ctr.sv
// rtl/fifo_credit_ctr.sv - free-slot credit counter mirroring the downstream FIFO
module fifo_credit_ctr
  import fifo_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CRW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_i,
  input  logic           rd_i,
  output logic [CRW-1:0] count_o
);

  logic [CRW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (wr_i && !rd_i) begin
      count_d = count_q - 1'b1;
    end else if (rd_i && !wr_i && count_q != CRW'(DEPTH)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= CRW'(DEPTH);
    else     count_q <= count_d;
  end

  assign count_o = count_q;

  // A read while every slot is free means the FIFO side is out of step with us.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(rd_i && !wr_i && count_q == CRW'(DEPTH)));

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_i && !rd_i && count_q == '0));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - credit-gated round-robin burst arbiter for one FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int DEPTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*DW-1:0]           req_data,
  output logic [NREQ-1:0]              ack,
  output logic                         fifo_wr_en,
  output logic [DW-1:0]                fifo_din,
  input  logic                         fifo_rd_fire,
  output logic [$clog2(DEPTH+1)-1:0]   credits,
  output logic                         busy
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              wr_en_q, wr_en_d;
  logic [DW-1:0]     din_q, din_d;
  rr_pick_t          pick;
  logic              credit_ok;

  assign credit_ok = (credits != '0);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    din_d       = din_q;
    ack_d       = '0;
    wr_en_d     = 1'b0;
    pick        = rr_pick(MAX_NREQ'(req), 3'(rr_ptr_q), NREQ);

    case (state_q)
      IDLE: begin
        if (pick.valid && credit_ok) begin
          wr_en_d     = 1'b1;
          owner_d     = IW'(pick.idx);
          burst_cnt_d = BW'(1);
          if (MAX_BURST == 1) rr_ptr_d = IW'((int'(pick.idx) + 1) % NREQ);
          else                state_d  = BURST;
        end
      end
      BURST: begin
        // Leaving a burst always costs one bubble cycle before the next grant.
        if (!req[owner_q] || burst_cnt_q == BW'(MAX_BURST)) begin
          rr_ptr_d = IW'((int'(owner_q) + 1) % NREQ);
          state_d  = IDLE;
        end else if (credit_ok) begin
          wr_en_d     = 1'b1;
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_en_d) begin
      ack_d[owner_d] = 1'b1;
      din_d          = req_data[owner_d*DW +: DW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      ack_q       <= '0;
      wr_en_q     <= 1'b0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      ack_q       <= ack_d;
      wr_en_q     <= wr_en_d;
      din_q       <= din_d;
    end
  end

  fifo_credit_ctr #(
    .DEPTH (DEPTH)
  ) u_credit_ctr (
    .clk     (clk),
    .rst     (rst),
    .wr_i    (wr_en_d),
    .rd_i    (fifo_rd_fire),
    .count_o (credits)
  );

  assign ack        = ack_q;
  assign fifo_wr_en = wr_en_q;
  assign fifo_din   = din_q;
  assign busy       = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed and randomized checks of fifo_wr_arbiter against a reference model
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DW        = 8;
  localparam int DEPTH     = 8;
  localparam int MAX_BURST = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*DW-1:0]    req_data = '0;
  logic                  fifo_rd_fire = 1'b0;
  logic [NREQ-1:0]       ack;
  logic                  fifo_wr_en;
  logic [DW-1:0]         fifo_din;
  logic [3:0]            credits;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  // Reference model: arbitration described as plain integers.
  bit              m_busy;
  int              m_owner, m_cnt, m_ptr, m_credits;
  logic [NREQ-1:0] m_ack;

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_din     (fifo_din),
    .fifo_rd_fire (fifo_rd_fire),
    .credits      (credits),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_credits = DEPTH; m_ack = '0;
  endtask

  task automatic step();
    int          widx;
    bit          wr;
    logic [DW-1:0] e_din;
    widx  = -1;
    wr    = 0;
    e_din = '0;
    if (!m_busy) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (widx < 0 && req[j]) widx = j;
      end
      if (widx >= 0 && m_credits > 0) begin
        wr = 1; m_owner = widx; m_cnt = 1;
        if (MAX_BURST == 1) m_ptr = (widx + 1) % NREQ;
        else                m_busy = 1;
      end
    end else begin
      if (!req[m_owner] || m_cnt == MAX_BURST) begin
        m_ptr  = (m_owner + 1) % NREQ;
        m_busy = 0;
      end else if (m_credits > 0) begin
        wr = 1; widx = m_owner; m_cnt++;
      end
    end
    if (wr) e_din = req_data[widx*DW +: DW];
    if (wr && !fifo_rd_fire) m_credits--;
    else if (fifo_rd_fire && !wr && m_credits < DEPTH) m_credits++;
    m_ack = wr ? NREQ'(1 << widx) : '0;
    @(posedge clk);
    #1;
    chk("ack", ack, m_ack);
    chk("wr_en", fifo_wr_en, wr);
    chk("credits", credits, m_credits);
    chk("busy", busy, m_busy);
    if (wr) chk("din", fifo_din, e_din);
  endtask

  task automatic drain_to(input int target);
    req = '0;
    for (int n = 0; n < 40 && m_credits < target; n++) begin
      fifo_rd_fire = 1'b1;
      step();
    end
    fifo_rd_fire = 1'b0;
    chk("drain_level", credits, target);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_ack", ack, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_din", fifo_din, 0);
    chk("rst_credits", credits, DEPTH);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single requester held for three words.
    req = 4'b0001;
    req_data[7:0] = 8'hA5;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("t1_ack0", ack, 4'b0001);
      chk("t1_din", fifo_din, 8'hA5);
    end
    chk("t1_credits", credits, 5);
    chk("t1_busy", busy, 1);
    req = '0;
    step();
    drain_to(DEPTH);

    // All requesting, no reads: two full bursts then credit stall.
    req = 4'b1111;
    req_data = 32'h44332211;
    for (int n = 0; n < 13; n++) step();
    chk("t2_credits", credits, 0);
    chk("t2_stall", fifo_wr_en, 0);

    // One read at zero credits buys exactly one write.
    fifo_rd_fire = 1'b1;
    step();
    fifo_rd_fire = 1'b0;
    chk("t3_credit1", credits, 1);
    step();
    chk("t3_write", fifo_wr_en, 1);
    chk("t3_credit0", credits, 0);
    step();
    chk("t3_hold", fifo_wr_en, 0);
    req = '0;
    step();
    drain_to(3);

    // Simultaneous write and read leaves credits unchanged.
    req = 4'b0001;
    fifo_rd_fire = 1'b1;
    step();
    fifo_rd_fire = 1'b0;
    chk("t4_write", fifo_wr_en, 1);
    chk("t4_credits", credits, 3);
    req = '0;
    step();
    drain_to(DEPTH);

    // Owner drops mid-burst: bubble, then next requester.
    req = 4'b0100;
    req_data = 32'hD0C0B0A0;
    step();
    chk("t5_ack2a", ack, 4'b0100);
    req = 4'b1100;
    req_data[23:16] = 8'hC1;
    step();
    chk("t5_ack2b", ack, 4'b0100);
    req = 4'b1000;
    step();
    chk("t5_bubble", fifo_wr_en, 0);
    step();
    chk("t5_ack3", ack, 4'b1000);
    req = '0;
    step();
    drain_to(DEPTH);

    // Randomized producers and FIFO reads.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_ack[i]) begin
          req_data[i*DW +: DW] = DW'($urandom);
          req[i] = ($urandom_range(0, 1) == 1);
        end else if (!req[i]) begin
          req[i] = ($urandom_range(0, 2) == 0);
          req_data[i*DW +: DW] = DW'($urandom);
        end
      end
      fifo_rd_fire = (m_credits < DEPTH) && ($urandom_range(0, 2) != 0);
      step();
    end
    fifo_rd_fire = 1'b0;
    req = '0;
    step();
    drain_to(DEPTH);

    // Reset in the middle of a burst.
    req = 4'b1111;
    step();
    step();
    chk("t6_pre_busy", busy, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_wr_en", fifo_wr_en, 0);
    chk("t6_ack", ack, 0);
    chk("t6_busy", busy, 0);
    chk("t6_credits", credits, DEPTH);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step();
    req = 4'b0010;
    step();
    chk("t6_regrant", ack, 4'b0010);
    req = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
